// File: rtl/reg_wb_queue.sv
// Speculative writeback holding queue: buffers execute results in program order,
// releases them to the register file on ROB retirement, and serves youngest-match lookups.
module reg_wb_queue #(
  parameter int DEPTH       = 16,
  parameter int WRITE_PORTS = 2,
  parameter int IDX_WIDTH   = 5,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_recover,
  input  logic [WRITE_PORTS-1:0]            i_spec_valid,
  input  logic [WRITE_PORTS*IDX_WIDTH-1:0]  i_spec_idx,
  input  logic [WRITE_PORTS*DATA_WIDTH-1:0] i_spec_data,
  output logic                              o_spec_ready,
  input  logic [$clog2(WRITE_PORTS+1)-1:0]  i_commit_cnt,
  output logic [WRITE_PORTS-1:0]            o_commit_valid,
  output logic [WRITE_PORTS*IDX_WIDTH-1:0]  o_commit_idx,
  output logic [WRITE_PORTS*DATA_WIDTH-1:0] o_commit_data,
  input  logic [IDX_WIDTH-1:0]              i_lookup_idx,
  output logic                              o_lookup_hit,
  output logic [DATA_WIDTH-1:0]             o_lookup_data,
  output logic [$clog2(DEPTH+1)-1:0]        o_count,
  output logic                              o_overflow,
  output logic                              o_underflow
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] WP_C    = CNT_W'(WRITE_PORTS);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);

  logic [IDX_WIDTH-1:0]  r_idx_mem  [DEPTH];
  logic [DATA_WIDTH-1:0] r_data_mem [DEPTH];
  logic [PTR_W-1:0]      r_head;
  logic [PTR_W-1:0]      r_tail;
  logic [CNT_W-1:0]      r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic [WRITE_PORTS-1:0]            r_cmt_valid_p1;
  logic [WRITE_PORTS*IDX_WIDTH-1:0]  r_cmt_idx_p1;
  logic [WRITE_PORTS*DATA_WIDTH-1:0] r_cmt_data_p1;

  logic                  w_ready;
  logic [CNT_W-1:0]      w_enq_raw;
  logic [CNT_W-1:0]      w_enq_n;
  logic [PTR_W-1:0]      w_slot [WRITE_PORTS];
  logic [CNT_W-1:0]      w_cmt_req;
  logic [CNT_W-1:0]      w_cmt_n;
  logic                  w_under;
  logic                  w_over;

  assign w_ready   = (DEPTH_C - r_count) >= WP_C;
  assign w_cmt_req = CNT_W'(i_commit_cnt);
  assign w_under   = w_cmt_req > r_count;
  assign w_cmt_n   = w_under ? r_count : w_cmt_req;
  assign w_over    = (|i_spec_valid) && !w_ready;
  assign w_enq_n   = w_ready ? w_enq_raw : '0;

  // Valid lanes are compacted onto consecutive tail slots in lane order.
  always_comb begin
    w_enq_raw = '0;
    for (int k = 0; k < WRITE_PORTS; k++) begin
      w_slot[k] = r_tail + PTR_W'(w_enq_raw);
      if (i_spec_valid[k]) w_enq_raw = w_enq_raw + ONE_C;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_ready) begin
      for (int k = 0; k < WRITE_PORTS; k++) begin
        if (i_spec_valid[k]) begin
          r_idx_mem[w_slot[k]]  <= i_spec_idx[k*IDX_WIDTH +: IDX_WIDTH];
          r_data_mem[w_slot[k]] <= i_spec_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_over)  r_overflow  <= 1'b1;
      if (w_under) r_underflow <= 1'b1;
      if (i_recover) begin
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        r_head  <= r_head + PTR_W'(w_cmt_n);
        r_tail  <= r_tail + PTR_W'(w_enq_n);
        r_count <= r_count + w_enq_n - w_cmt_n;
      end
    end
  end

  // Stage p1: commit lanes registered; slots read here are never written this cycle.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cmt_valid_p1 <= '0;
      r_cmt_idx_p1   <= '0;
      r_cmt_data_p1  <= '0;
    end else begin
      r_cmt_valid_p1 <= '0;
      r_cmt_idx_p1   <= '0;
      r_cmt_data_p1  <= '0;
      for (int k = 0; k < WRITE_PORTS; k++) begin
        if (!i_recover && (CNT_W'(k) < w_cmt_n)) begin
          r_cmt_valid_p1[k]                          <= 1'b1;
          r_cmt_idx_p1[k*IDX_WIDTH +: IDX_WIDTH]     <= r_idx_mem[r_head + PTR_W'(k)];
          r_cmt_data_p1[k*DATA_WIDTH +: DATA_WIDTH]  <= r_data_mem[r_head + PTR_W'(k)];
        end
      end
    end
  end

  // Scan oldest to youngest so the last match left standing is the youngest.
  always_comb begin
    o_lookup_hit  = 1'b0;
    o_lookup_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((CNT_W'(i) < r_count) && (i_lookup_idx != '0) &&
          (r_idx_mem[r_head + PTR_W'(i)] == i_lookup_idx)) begin
        o_lookup_hit  = 1'b1;
        o_lookup_data = r_data_mem[r_head + PTR_W'(i)];
      end
    end
  end

  assign o_spec_ready   = w_ready;
  assign o_count        = r_count;
  assign o_overflow     = r_overflow;
  assign o_underflow    = r_underflow;
  assign o_commit_valid = r_cmt_valid_p1;
  assign o_commit_idx   = r_cmt_idx_p1;
  assign o_commit_data  = r_cmt_data_p1;

endmodule
